// File: rtl/line_buffer3_pkg.sv
// Shared definitions for the line_buffer3 row buffer.
//   WID_FIFO      : default pixel width; matches the shift_register3 data width
//   DEFAULT_MAX_W : default maximum row width (row memory depth)
//   state_e       : control FSM state encoding
package line_buffer3_pkg;

    localparam int WID_FIFO      = 8;
    localparam int DEFAULT_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_e;

endpackage

// File: rtl/line_buffer3_mem.sv
// line_mem: row memory with one synchronous write port and one asynchronous
// read port on the same address, so a read-modify-write of one column happens
// in a single cycle.
// Ports:
//   clk   : system clock
//   we    : write enable
//   addr  : column address, shared by read and write
//   wdata : data written at addr on the rising edge when we=1
//   rdata : current contents of addr (the value before any write this cycle)
module line_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rdata = mem_q[addr];

    // NOTE: the storage array has no reset; its contents are never consumed
    // before being rewritten, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/line_buffer3.sv
// line_buffer3: raster-order pixel stream to three vertically aligned pixels.
// Two row memories hold the previous two rows. For every accepted pixel the
// block emits, one cycle later, the current pixel and the pixels one and two
// rows above it, together with the shift strobe for the downstream
// shift_register3 instances.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   cfg_row_width       : pixels per row, sampled at frame start
//   cfg_frame_rows      : rows per frame, sampled at frame start
//   in_valid/in_ready   : input handshake; in_data is the pixel
//   stall               : convolver backpressure, blocks acceptance
//   shifting            : one-cycle strobe, outputs below are new
//   out_row0/1/2        : current row, row-1, row-2 pixel
//   win_valid           : a full 3x3 window is present after this shift
//   row_done/frame_done : last pixel of a row / frame was accepted
//   cfg_err             : sticky configuration error, cleared only by reset
module line_buffer3
    import line_buffer3_pkg::*;
#(
    parameter int DATA_W    = WID_FIFO,
    parameter int MAX_W     = DEFAULT_MAX_W,
    parameter int ADDR_W    = 6,
    parameter int ROW_CNT_W = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W:0]      cfg_row_width,
    input  logic [ROW_CNT_W-1:0] cfg_frame_rows,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 stall,
    output logic                 shifting,
    output logic [DATA_W-1:0]    out_row0,
    output logic [DATA_W-1:0]    out_row1,
    output logic [DATA_W-1:0]    out_row2,
    output logic                 win_valid,
    output logic                 row_done,
    output logic                 frame_done,
    output logic                 cfg_err
);

    localparam logic [ADDR_W:0]      MAX_WIDTH = (ADDR_W+1)'(MAX_W);
    localparam logic [ADDR_W:0]      MIN_WIDTH = 3;
    localparam logic [ADDR_W:0]      ONE_W     = 1;
    localparam logic [ADDR_W-1:0]    ONE_C     = 1;
    localparam logic [ADDR_W-1:0]    TWO_C     = 2;
    localparam logic [ROW_CNT_W-1:0] ONE_R     = 1;
    localparam logic [ROW_CNT_W-1:0] TWO_R     = 2;
    localparam logic [ROW_CNT_W-1:0] MIN_ROWS  = 3;

    state_e               state_q, state_d;
    logic [ADDR_W:0]      width_q, width_d;
    logic [ROW_CNT_W-1:0] rows_q, rows_d;
    logic [ADDR_W-1:0]    col_q, col_d;
    logic [ROW_CNT_W-1:0] row_q, row_d;
    logic [DATA_W-1:0]    out_row0_q, out_row0_d;
    logic [DATA_W-1:0]    out_row1_q, out_row1_d;
    logic [DATA_W-1:0]    out_row2_q, out_row2_d;
    logic                 shifting_q, shifting_d;
    logic                 win_valid_q, win_valid_d;
    logic                 row_done_q, row_done_d;
    logic                 frame_done_q, frame_done_d;
    logic                 cfg_err_q, cfg_err_d;

    logic                 accept;
    logic                 ready;
    logic                 cfg_bad;
    logic                 last_col;
    logic                 last_row;
    logic [DATA_W-1:0]    mem0_rdata;
    logic [DATA_W-1:0]    mem1_rdata;

    // mem0 holds row-1, mem1 holds row-2. Each accepted pixel pushes the
    // column down one row: in_data -> mem0[c], old mem0[c] -> mem1[c].
    line_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_W),
        .ADDR_W (ADDR_W)
    ) mem0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_q),
        .wdata (in_data),
        .rdata (mem0_rdata)
    );

    line_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_W),
        .ADDR_W (ADDR_W)
    ) mem1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_q),
        .wdata (mem0_rdata),
        .rdata (mem1_rdata)
    );

    assign cfg_bad  = (cfg_row_width < MIN_WIDTH) || (cfg_row_width > MAX_WIDTH) ||
                      (cfg_frame_rows < MIN_ROWS);
    assign last_col = ({1'b0, col_q} == (width_q - ONE_W));
    assign last_row = (row_q == (rows_q - ONE_R));

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        width_d      = width_q;
        rows_d       = rows_q;
        col_d        = col_q;
        row_d        = row_q;
        out_row0_d   = out_row0_q;
        out_row1_d   = out_row1_q;
        out_row2_d   = out_row2_q;
        win_valid_d  = win_valid_q;
        shifting_d   = 1'b0;
        row_done_d   = 1'b0;
        frame_done_d = 1'b0;
        cfg_err_d    = cfg_err_q;
        ready        = 1'b0;
        accept       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The pixel that wakes the FSM is held by the source and is
                // accepted on a later cycle once RUN raises in_ready.
                if (in_valid) begin
                    width_d = cfg_row_width;
                    rows_d  = cfg_frame_rows;
                    col_d   = '0;
                    row_d   = '0;
                    if (cfg_bad) begin
                        state_d   = ERR;
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                ready  = ~stall;
                accept = in_valid & ~stall;
                if (accept) begin
                    shifting_d  = 1'b1;
                    out_row0_d  = in_data;
                    out_row1_d  = mem0_rdata;
                    out_row2_d  = mem1_rdata;
                    win_valid_d = (row_q >= TWO_R) && (col_q >= TWO_C);
                    row_done_d  = last_col;
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            // Back to IDLE so the next frame re-samples cfg.
                            frame_done_d = 1'b1;
                            row_d        = '0;
                            state_d      = IDLE;
                        end else begin
                            row_d = row_q + ONE_R;
                        end
                    end else begin
                        col_d = col_q + ONE_C;
                    end
                end
            end

            ERR: begin
                // Sticky until reset.
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            width_q      <= '0;
            rows_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            out_row0_q   <= '0;
            out_row1_q   <= '0;
            out_row2_q   <= '0;
            shifting_q   <= 1'b0;
            win_valid_q  <= 1'b0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            rows_q       <= rows_d;
            col_q        <= col_d;
            row_q        <= row_d;
            out_row0_q   <= out_row0_d;
            out_row1_q   <= out_row1_d;
            out_row2_q   <= out_row2_d;
            shifting_q   <= shifting_d;
            win_valid_q  <= win_valid_d;
            row_done_q   <= row_done_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign in_ready   = ready;
    assign shifting   = shifting_q;
    assign out_row0   = out_row0_q;
    assign out_row1   = out_row1_q;
    assign out_row2   = out_row2_q;
    assign win_valid  = win_valid_q;
    assign row_done   = row_done_q;
    assign frame_done = frame_done_q;
    assign cfg_err    = cfg_err_q;

endmodule
